// File: rtl/dadda_multiplier_16.sv
// 16x16 unsigned multiplier: Dadda reduction tree feeding a ripple adder.
// Combinational product plus a synchronously reset registered copy.
module dadda_multiplier_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] result,
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] result_q
);

    localparam int NSTG = 6;
    localparam int TGT [NSTG] = '{13, 9, 6, 4, 3, 2};

    // Column-wise bit bags; each stage adds only enough FA/HA to hit its height target.
    function automatic logic [31:0] dadda_mul(
        input logic [15:0] x,
        input logic [15:0] y
    );
        logic [15:0] cur [32];
        logic [15:0] nxt [32];
        int          hc  [32];
        int          hn  [32];
        int          p;
        int          ex;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] sum;
        logic        c;
        logic        u;
        logic        v;
        logic        w;

        for (int k = 0; k < 32; k++) begin
            cur[k] = '0;
            hc[k]  = 0;
        end
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                cur[i + j][4'(hc[i + j])] = x[j] & y[i];
                hc[i + j] = hc[i + j] + 1;
            end
        end

        for (int s = 0; s < NSTG; s++) begin
            for (int k = 0; k < 32; k++) begin
                nxt[k] = '0;
                hn[k]  = 0;
            end
            for (int k = 0; k < 32; k++) begin
                p = 0;
                for (int n = 0; n < 8; n++) begin
                    ex = hc[k] - p + hn[k] - TGT[s];
                    if (ex >= 2) begin
                        u = cur[k][4'(p)];
                        v = cur[k][4'(p + 1)];
                        w = cur[k][4'(p + 2)];
                        nxt[k][4'(hn[k])] = u ^ v ^ w;
                        hn[k] = hn[k] + 1;
                        if (k < 31) begin
                            nxt[k + 1][4'(hn[k + 1])] = (u & v) | (u & w) | (v & w);
                            hn[k + 1] = hn[k + 1] + 1;
                        end
                        p = p + 3;
                    end else if (ex == 1) begin
                        u = cur[k][4'(p)];
                        v = cur[k][4'(p + 1)];
                        nxt[k][4'(hn[k])] = u ^ v;
                        hn[k] = hn[k] + 1;
                        if (k < 31) begin
                            nxt[k + 1][4'(hn[k + 1])] = u & v;
                            hn[k + 1] = hn[k + 1] + 1;
                        end
                        p = p + 2;
                    end
                end
                for (int i = 0; i < 16; i++) begin
                    if (i >= p && i < hc[k]) begin
                        nxt[k][4'(hn[k])] = cur[k][i];
                        hn[k] = hn[k] + 1;
                    end
                end
            end
            cur = nxt;
            hc  = hn;
        end

        for (int k = 0; k < 32; k++) begin
            r0[k] = (hc[k] > 0) ? cur[k][0] : 1'b0;
            r1[k] = (hc[k] > 1) ? cur[k][1] : 1'b0;
        end

        c = 1'b0;
        for (int k = 0; k < 32; k++) begin
            sum[k] = r0[k] ^ r1[k] ^ c;
            c      = (r0[k] & r1[k]) | (c & (r0[k] ^ r1[k]));
        end
        return sum;
    endfunction

    always_comb begin
        result = dadda_mul(a, b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 32'h0;
        end else begin
            result_q <= result;
        end
    end

endmodule

// File: tb/tb_dadda_multiplier_16.sv
// Bench for dadda_multiplier_16: directed table, random vs. arithmetic
// model, and registered-path/reset sequences.
module tb_dadda_multiplier_16;

    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] result;
    logic        clk;
    logic        rst;
    logic [31:0] result_q;

    int n_run  = 0;
    int n_fail = 0;
    int n_mis  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [8];

    dadda_multiplier_16 dut (
        .a        (a),
        .b        (b),
        .result   (result),
        .clk      (clk),
        .rst      (rst),
        .result_q (result_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{16'h0000, 16'h1234, 32'h0000_0000, "zero_a"};
        vecs[1] = '{16'h1234, 16'h0000, 32'h0000_0000, "zero_b"};
        vecs[2] = '{16'h0001, 16'hBEEF, 32'h0000_BEEF, "identity"};
        vecs[3] = '{16'h8000, 16'h0002, 32'h0001_0000, "pow2_a"};
        vecs[4] = '{16'h8000, 16'h8000, 32'h4000_0000, "pow2_sq"};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max"};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF, "max_by_one"};
        vecs[7] = '{16'h00FF, 16'hFF00, 32'h00FE_0100, "byte_mix"};

        rst = 1'b1;
        a   = 16'h0;
        b   = 16'h0;
        @(posedge clk);
        #1;
        check("reset_q", result_q, 32'h0);

        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a;
            b = vecs[i].b;
            #5;
            check(vecs[i].name, result, vecs[i].exp);
            #5;
        end

        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            #5;
            if (result !== ref_mul(a, b)) n_mis++;
            check("random", result, ref_mul(a, b));
            #5;
        end
        if (n_mis == 0) $display("Success");
        else $display("Design Failure");

        @(negedge clk);
        rst = 1'b1;
        a   = 16'd3;
        b   = 16'd5;
        @(posedge clk);
        #1;
        check("rst_edge1_q", result_q, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge2_q", result_q, 32'd0);
        check("rst_comb", result, 32'd15);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("deassert_q", result_q, 32'd15);

        @(negedge clk);
        a = 16'd7;
        b = 16'd9;
        @(posedge clk);
        #1;
        check("reg_63", result_q, 32'd63);

        a = 16'd2;
        b = 16'd2;
        #3;
        a = 16'd4;
        b = 16'd4;
        @(posedge clk);
        #1;
        check("midcycle_q", result_q, 32'd16);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            #1;
            check("reg_random", result_q, ref_mul(a, b));
        end

        @(negedge clk);
        a   = 16'hFFFF;
        b   = 16'hFFFF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_again_q", result_q, 32'd0);
        check("rst_again_comb", result, 32'hFFFE_0001);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
